// File: rtl/fetch_pkg.sv
// Shared opcode constants, sequencer state encoding and skip decode for the
// program sequencer and the datapath decoder.
package fetch_pkg;

  localparam logic [3:0] OP_LDA  = 4'b0000;
  localparam logic [3:0] OP_LDB  = 4'b0001;
  localparam logic [3:0] OP_LDO  = 4'b0010;
  localparam logic [3:0] OP_LDSA = 4'b0011;
  localparam logic [3:0] OP_LDSB = 4'b0100;
  localparam logic [3:0] OP_LSH  = 4'b0101;
  localparam logic [3:0] OP_RSH  = 4'b0110;
  localparam logic [3:0] OP_CLR  = 4'b0111;
  localparam logic [3:0] OP_SNZA = 4'b1000;
  localparam logic [3:0] OP_SNZS = 4'b1001;
  localparam logic [3:0] OP_ADD  = 4'b1010;
  localparam logic [3:0] OP_SUB  = 4'b1011;
  localparam logic [3:0] OP_XOR  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // True when the opcode is a conditional skip whose flag is set.
  function automatic logic is_skip(input logic [3:0] op, input logic a_nz,
                                   input logic s_nz);
    return ((op == OP_SNZA) && a_nz) || ((op == OP_SNZS) && s_nz);
  endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// ROM port plus the instruction issue handshake and datapath flags seen by
// the sequencer; master is the sequencer side.
interface instr_fetch_seq_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [3:0]            rom_data;
  logic [3:0]            instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  a_nz;
  logic                  s_nz;

  modport master (
    output rom_addr, instr, instr_valid,
    input  rom_data, instr_ready, a_nz, s_nz
  );

  modport slave (
    input  rom_addr, instr, instr_valid,
    output rom_data, instr_ready, a_nz, s_nz
  );
endinterface

// File: rtl/instr_fetch_seq_pc_counter.sv
// Program counter with load-zero, fetch increment and skip increment; end_o
// reports whether the pc after an optional skip lies past the program.
module pc_counter #(
  parameter int ADDR_WIDTH = 8,
  parameter int PROG_LEN   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_zero,
  input  logic                  inc,
  input  logic                  inc2,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  end_o
);

  localparam logic [ADDR_WIDTH:0] PROG_END = (ADDR_WIDTH+1)'(PROG_LEN);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  wrap_q, wrap_d;
  logic [ADDR_WIDTH:0]   inc_sum;
  logic [ADDR_WIDTH:0]   np_ext;

  // wrap_q remembers a carry out of the address so a wrapped pc of 0 still
  // compares as past the end instead of aliasing to the first word.
  always_comb begin
    inc_sum = {1'b0, pc_q} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    np_ext  = {wrap_q, pc_q} + {{ADDR_WIDTH{1'b0}}, inc2};
    end_o   = (np_ext >= PROG_END);
    pc_d    = pc_q;
    wrap_d  = wrap_q;
    if (load_zero) begin
      pc_d   = '0;
      wrap_d = 1'b0;
    end else if (inc || inc2) begin
      pc_d   = inc_sum[ADDR_WIDTH-1:0];
      wrap_d = wrap_q | inc_sum[ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer: fetches opcodes from the ROM, issues them over a
// valid/ready handshake, applies SNZA/SNZS skips and halts at program end.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_FETCH | IR <- rom_data at pc, pc advances
// ST_ISSUE | instr_valid high, holding until instr_ready
// ST_HALT  | program finished, instr=CLR, pc frozen, start restarts
module instr_fetch_seq
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int PROG_LEN   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_fetch_seq_if.master   bus,
  output logic                busy,
  output logic                halted
);

  fetch_state_e          state_q, state_d;
  logic [3:0]            ir_q, ir_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic                  pc_zero, pc_inc, pc_inc2;
  logic                  pc_end;
  logic [ADDR_WIDTH-1:0] pc;

  pc_counter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .PROG_LEN  (PROG_LEN)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_zero(pc_zero),
    .inc      (pc_inc),
    .inc2     (pc_inc2),
    .pc       (pc),
    .end_o    (pc_end)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    halted_d = halted_q;
    pc_zero  = 1'b0;
    pc_inc   = 1'b0;
    pc_inc2  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d  = ST_FETCH;
          pc_zero  = 1'b1;
          busy_d   = 1'b1;
          halted_d = 1'b0;
        end
      end
      ST_FETCH: begin
        ir_d    = bus.rom_data;
        pc_inc  = 1'b1;
        valid_d = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Flags only matter on the accepting edge; pc_end already folds in the skip.
        if (bus.instr_ready) begin
          pc_inc2 = is_skip(ir_q, bus.a_nz, bus.s_nz);
          valid_d = 1'b0;
          if (pc_end) begin
            state_d  = ST_HALT;
            ir_d     = OP_CLR;
            busy_d   = 1'b0;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_FETCH;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ir_d     = OP_CLR;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ir_q     <= OP_CLR;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.instr       = ir_q;
  assign bus.instr_valid = valid_q;
  assign busy            = busy_q;
  assign halted          = halted_q;

endmodule
